// File: rtl/round_sequencer_if.sv
// Handshake bundle between the round sequencer and its environment:
// the player's go pulse on one side, the move checker's start/verdict on the other.
interface round_sequencer_if;
    logic        go;
    logic        ready_in;
    logic        correct_in;
    logic        start;
    logic [12:0] move;
    logic [28:0] play_freq;
    logic [9:0]  score;
    logic [1:0]  lives;
    logic        playing;
    logic        game_over;
    logic        hit;
    logic        miss;

    modport master (
        output go, ready_in, correct_in,
        input  start, move, play_freq, score, lives, playing, game_over, hit, miss
    );

    modport slave (
        input  go, ready_in, correct_in,
        output start, move, play_freq, score, lives, playing, game_over, hit, miss
    );
endinterface

// File: rtl/round_sequencer.sv
// Game-round controller: draws a random one-hot move, starts the checker,
// then scores its verdict and shortens the play interval after every hit.
module round_sequencer #(
    parameter int unsigned INIT_FREQ     = 100000000,
    parameter int unsigned MIN_FREQ      = 25000000,
    parameter int unsigned SPEEDUP_SHIFT = 4,
    parameter int unsigned LIVES         = 3,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input logic              clk,
    input logic              rst,
    round_sequencer_if.slave bus
);
    localparam logic [28:0] INIT_F    = 29'(INIT_FREQ);
    localparam logic [28:0] MIN_F     = 29'(MIN_FREQ);
    localparam logic [1:0]  LIVES_V   = 2'(LIVES);
    localparam logic [15:0] SEED_V    = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {IDLE, DRAW, ISSUE, WAIT, OVER} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_lfsr;
    logic [12:0] r_move;
    logic [28:0] r_freq;
    logic [9:0]  r_score;
    logic [1:0]  r_lives;
    logic        r_playing;
    logic        r_game_over;
    logic        r_hit;
    logic        r_miss;

    logic [3:0]  w_idx;
    logic        w_draw_ok;
    logic        w_go_ok;
    logic        w_eval;

    function automatic logic [9:0] f_sat_score(input logic [9:0] s);
        return (s >= 10'd999) ? 10'd999 : s + 10'd1;
    endfunction

    function automatic logic [28:0] f_speedup(input logic [28:0] f);
        logic [28:0] nf;
        nf = f - (f >> SPEEDUP_SHIFT);
        return (nf < MIN_F) ? MIN_F : nf;
    endfunction

    assign w_idx     = r_lfsr[3:0];
    assign w_draw_ok = (w_idx < 4'd13);
    assign w_go_ok   = ((r_state == IDLE) || (r_state == OVER)) && bus.go;
    assign w_eval    = (r_state == WAIT) && bus.ready_in;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, OVER: if (bus.go) w_next = DRAW;
            DRAW:       if (w_draw_ok) w_next = ISSUE;
            ISSUE:      w_next = WAIT;
            WAIT: begin
                if (bus.ready_in) begin
                    if (bus.correct_in)        w_next = DRAW;
                    else if (r_lives == 2'd1)  w_next = OVER;
                    else                       w_next = DRAW;
                end
            end
            default:    w_next = IDLE;
        endcase
    end

    // LFSR free-runs in every state so the draw depends on when the player pressed go
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr      <= SEED_V;
            r_move      <= '0;
            r_freq      <= INIT_F;
            r_score     <= '0;
            r_lives     <= LIVES_V;
            r_playing   <= 1'b0;
            r_game_over <= 1'b0;
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
            r_hit  <= w_eval && bus.correct_in;
            r_miss <= w_eval && !bus.correct_in;

            if (w_go_ok) begin
                r_score     <= '0;
                r_lives     <= LIVES_V;
                r_freq      <= INIT_F;
                r_playing   <= 1'b1;
                r_game_over <= 1'b0;
            end

            if ((r_state == DRAW) && w_draw_ok)
                r_move <= 13'b1 << w_idx;

            // Interval only moves here, so the checker never sees it change mid-round
            if (w_eval) begin
                if (bus.correct_in) begin
                    r_score <= f_sat_score(r_score);
                    r_freq  <= f_speedup(r_freq);
                end else begin
                    r_lives <= r_lives - 2'd1;
                    if (r_lives == 2'd1) begin
                        r_playing   <= 1'b0;
                        r_game_over <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.start     = (r_state == ISSUE);
    assign bus.move      = r_move;
    assign bus.play_freq = r_freq;
    assign bus.score     = r_score;
    assign bus.lives     = r_lives;
    assign bus.playing   = r_playing;
    assign bus.game_over = r_game_over;
    assign bus.hit       = r_hit;
    assign bus.miss      = r_miss;
endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer: the driver queues the expected start/hit/miss
// events, a negedge monitor pops and compares each one the DUT produces.
module tb_round_sequencer;
    logic clk;
    logic rst;
    round_sequencer_if bus();

    round_sequencer #(
        .INIT_FREQ(64), .MIN_FREQ(16), .SPEEDUP_SHIFT(2), .LIVES(3), .SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 = start, 1 = hit, 2 = miss
        int score;
        int lives;
        int freq;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_score, m_lives, m_freq, m_hits;

    exp_t mon_e;
    int   mon_kind;
    bit   mon_ok;

    always @(negedge clk) begin
        if (!rst && (bus.start || bus.hit || bus.miss)) begin
            total++;
            if ((int'(bus.start) + int'(bus.hit) + int'(bus.miss)) > 1) mon_kind = 3;
            else if (bus.start) mon_kind = 0;
            else if (bus.hit)   mon_kind = 1;
            else                mon_kind = 2;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event kind=%0d score=%0d lives=%0d freq=%0d (none expected)",
                         mon_kind, bus.score, bus.lives, bus.play_freq);
            end else begin
                mon_e  = q.pop_front();
                mon_ok = (mon_kind == mon_e.kind) && (int'(bus.score) == mon_e.score) &&
                         (int'(bus.lives) == mon_e.lives) && (int'(bus.play_freq) == mon_e.freq);
                if (mon_kind == 0)
                    mon_ok = mon_ok && bus.playing && (bus.move != 13'd0) &&
                             ((bus.move & (bus.move - 13'd1)) == 13'd0);
                if (!mon_ok) begin
                    bad++;
                    $display("FAIL event: got kind=%0d score=%0d lives=%0d freq=%0d move=%b playing=%0b, want kind=%0d score=%0d lives=%0d freq=%0d",
                             mon_kind, bus.score, bus.lives, bus.play_freq, bus.move, bus.playing,
                             mon_e.kind, mon_e.score, mon_e.lives, mon_e.freq);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_start"},     int'(bus.start),     0);
        chk({tag, "_hit"},       int'(bus.hit),       0);
        chk({tag, "_miss"},      int'(bus.miss),      0);
        chk({tag, "_playing"},   int'(bus.playing),   0);
        chk({tag, "_game_over"}, int'(bus.game_over), 0);
        chk({tag, "_move"},      int'(bus.move),      0);
        chk({tag, "_score"},     int'(bus.score),     0);
        chk({tag, "_lives"},     int'(bus.lives),     3);
        chk({tag, "_freq"},      int'(bus.play_freq), 64);
    endtask

    function automatic int exp_freq(input int n);
        case (n)
            0:       return 48;
            1:       return 36;
            2:       return 27;
            3:       return 21;
            default: return 16;
        endcase
    endfunction

    task automatic expect_start();
        exp_t e;
        e.kind = 0; e.score = m_score; e.lives = m_lives; e.freq = m_freq;
        q.push_back(e);
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.start && cyc < 200);
        if (!bus.start) chk("start_timeout", 0, 1);
    endtask

    task automatic verdict(input bit c, input bit go_in_wait);
        exp_t e;
        int   cyc;
        if (go_in_wait) begin
            @(negedge clk);
            bus.go = 1'b1;
            @(negedge clk);
            bus.go = 1'b0;
        end
        if (c) begin
            m_score = (m_score < 999) ? m_score + 1 : 999;
            m_freq  = exp_freq(m_hits);
            m_hits++;
            e.kind = 1;
        end else begin
            m_lives--;
            e.kind = 2;
        end
        e.score = m_score; e.lives = m_lives; e.freq = m_freq;
        q.push_back(e);
        bus.ready_in   = 1'b1;
        bus.correct_in = c;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(bus.hit || bus.miss) && cyc < 200);
        if (!(bus.hit || bus.miss)) chk("verdict_timeout", 0, 1);
        bus.ready_in   = 1'b0;
        bus.correct_in = 1'b0;
    endtask

    task automatic round(input bit c, input bit stale, input bit go_in_wait);
        int cyc;
        bit seen;
        if (stale) bus.ready_in = 1'b1;
        expect_start();
        wait_start(cyc);
        if (stale) begin
            @(negedge clk);
            bus.ready_in = 1'b0;
            seen = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (bus.hit || bus.miss) seen = 1'b1;
            end
            chk("stale_ready_no_eval", int'(seen), 0);
        end
        verdict(c, go_in_wait);
    endtask

    task automatic no_start(input string name, input int n);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (bus.start) seen = 1'b1;
        end
        chk(name, int'(seen), 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        bus.go = 1'b0; bus.ready_in = 1'b0; bus.correct_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        m_score = 0; m_lives = 3; m_freq = 64; m_hits = 0;

        // First game: start latency, then six hits walking the interval down to the floor
        expect_start();
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        wait_start(cyc);
        total++;
        if (!(cyc + 1 >= 2 && cyc + 1 <= 17)) begin
            bad++;
            $display("FAIL first_start_latency: got %0d cycles, want 2..17", cyc + 1);
        end
        @(negedge clk);
        chk("start_one_cycle", int'(bus.start), 0);
        verdict(1'b1, 1'b0);
        repeat (5) round(1'b1, 1'b0, 1'b0);
        chk("score_after_six", int'(bus.score), 6);
        chk("freq_clamped", int'(bus.play_freq), 16);

        // Three misses: stale ready, go during WAIT, then the game-ending one
        round(1'b0, 1'b1, 1'b0);
        round(1'b0, 1'b0, 1'b1);
        chk("score_kept_after_go_in_wait", int'(bus.score), 6);
        round(1'b0, 1'b0, 1'b0);
        chk("over_game_over", int'(bus.game_over), 1);
        chk("over_playing", int'(bus.playing), 0);
        chk("over_lives", int'(bus.lives), 0);
        no_start("no_start_in_over", 20);

        // New game from OVER, then 1000 hits to exercise score saturation
        m_score = 0; m_lives = 3; m_freq = 64; m_hits = 0;
        expect_start();
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        chk("regame_score", int'(bus.score), 0);
        chk("regame_lives", int'(bus.lives), 3);
        chk("regame_freq", int'(bus.play_freq), 64);
        chk("regame_playing", int'(bus.playing), 1);
        chk("regame_game_over", int'(bus.game_over), 0);
        wait_start(cyc);
        verdict(1'b1, 1'b0);
        repeat (999) round(1'b1, 1'b0, 1'b0);
        chk("score_saturated", int'(bus.score), 999);

        // Reset while waiting for a verdict
        expect_start();
        wait_start(cyc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("midgame_reset");
        rst = 1'b0;
        no_start("idle_after_reset", 20);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
